// File: rtl/burst_ram_responder.sv
// burst_ram_responder: BurstRAM command responder backed by an on-chip beat array.
// Optional BURST_RAM_INIT_DELAY_EN holds busy high for INIT_CYCLES after reset.
module burst_ram_responder #(
  parameter int DATA_BITWIDTH  = 64,
  parameter int DEPTH_BITWIDTH = 8,
  parameter int BURST_COUNT    = 4,
  parameter int READ_LATENCY   = 4,
  parameter int INIT_CYCLES    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd,
  input  logic                         cmd_en,
  input  logic [DEPTH_BITWIDTH-1:0]    addr,
  input  logic [DATA_BITWIDTH-1:0]     wr_data,
  input  logic [DATA_BITWIDTH/8-1:0]   data_mask,
  output logic [DATA_BITWIDTH-1:0]     rd_data,
  output logic                         rd_data_valid,
  output logic                         busy
);
  localparam int BW = $clog2(BURST_COUNT);
  localparam int LW = $clog2(READ_LATENCY) + 1;
  localparam int NB = DATA_BITWIDTH / 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST} state_t;

  state_t                    state_q, state_d;
  logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [LW-1:0]             lat_q, lat_d;
  logic [DATA_BITWIDTH-1:0]  rd_data_q, rd_data_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [DATA_BITWIDTH-1:0]  mem [2**DEPTH_BITWIDTH];
  logic [DEPTH_BITWIDTH-1:0] mem_addr;
  logic                      init_busy, accept, wr_en, rd_en;

  if (BURST_COUNT < 2 || (BURST_COUNT & (BURST_COUNT - 1)) != 0 || READ_LATENCY < 1 ||
      DATA_BITWIDTH % 8 != 0 || INIT_CYCLES < 0) begin : g_bad_param
    $error("burst_ram_responder: illegal parameter set");
  end

`ifdef BURST_RAM_INIT_DELAY_EN
  localparam int IW = $clog2(INIT_CYCLES + 2);
  logic [IW-1:0] init_q, init_d;
  always_comb init_d = init_q != '0 ? init_q - 1'b1 : init_q;
  always_ff @(posedge clk) init_q <= rst ? IW'(INIT_CYCLES) : init_d;
  assign init_busy = init_q != '0;
`else
  assign init_busy = 1'b0;
`endif

  assign busy          = state_q != IDLE || init_busy;
  assign accept        = cmd_en && !busy;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;

  // beat_q wraps to 0 after the last read beat; RD_BURST uses that to spend one closing cycle
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    lat_d      = lat_q;
    rd_valid_d = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    mem_addr   = addr_q + DEPTH_BITWIDTH'(beat_q);
    case (state_q)
      IDLE: if (accept) begin
        addr_d   = addr;
        mem_addr = addr;
        beat_d   = BW'(1);
        if (cmd) begin
          wr_en   = 1'b1;
          state_d = WR_BURST;
        end else if (READ_LATENCY == 1) begin
          rd_en      = 1'b1;
          rd_valid_d = 1'b1;
          state_d    = RD_BURST;
        end else begin
          beat_d  = '0;
          lat_d   = LW'(READ_LATENCY - 1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (lat_q == LW'(1)) begin
        rd_en      = 1'b1;
        rd_valid_d = 1'b1;
        beat_d     = BW'(1);
        state_d    = RD_BURST;
      end else begin
        lat_d = lat_q - 1'b1;
      end
      RD_BURST: if (beat_q == '0) begin
        state_d = IDLE;
      end else begin
        rd_en      = 1'b1;
        rd_valid_d = 1'b1;
        beat_d     = beat_q + 1'b1;
      end
      WR_BURST: begin
        wr_en   = 1'b1;
        beat_d  = beat_q + 1'b1;
        state_d = beat_q == BW'(BURST_COUNT - 1) ? IDLE : WR_BURST;
      end
      default: state_d = IDLE;
    endcase
    rd_data_d = rd_en ? mem[mem_addr] : rd_data_q;
  end

  always_ff @(posedge clk)
    if (wr_en && !rst)
      for (int b = 0; b < NB; b++)
        if (!data_mask[b]) mem[mem_addr][8*b +: 8] <= wr_data[8*b +: 8];

  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      lat_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      lat_q      <= lat_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
endmodule

// File: tb/tb_burst_ram_responder.sv
// tb_burst_ram_responder: directed and random bursts checked each cycle against a burst-level model.
module tb_burst_ram_responder;
  localparam int BC = 4;
  localparam int L  = 4;

  logic        clk = 1'b0;
  logic        rst, cmd, cmd_en;
  logic [7:0]  addr, data_mask;
  logic [63:0] wr_data, rd_data;
  logic        rd_data_valid, busy;

  always #5 clk = ~clk;

  burst_ram_responder dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .busy(busy)
  );

  int          checks = 0, failures = 0, cyc = 0;
  int          busy_until = 0, rd_start = -1000, wr_start = -1000, wr_end = -1000;
  logic [7:0]  wr_base = '0;
  logic [63:0] mem_m [256];
  logic [63:0] rd_snap [BC];
  logic [63:0] exp_rd = '0;
  logic [63:0] got [$];
  bit          chk = 0;

  function automatic logic [63:0] pat(input int x);
    return {8{8'(x)}};
  endfunction

  function automatic logic [63:0] gv(input int i);
    return i < got.size() ? got[i] : 'x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // one clock cycle: compare outputs of this cycle, then drive inputs and advance the model
  task automatic step(input logic r, input logic ce, input logic c, input logic [7:0] a,
                      input logic [63:0] wd, input logic [7:0] m);
    logic ev;
    if (chk) begin
      ev = cyc >= rd_start && cyc < rd_start + BC;
      if (ev) exp_rd = rd_snap[cyc - rd_start];
      check("rd_data_valid", 64'(rd_data_valid), 64'(ev));
      check("busy", 64'(busy), 64'(cyc < busy_until));
      check("rd_data", rd_data, exp_rd);
      if (rd_data_valid) got.push_back(rd_data);
    end
    rst = r; cmd_en = ce; cmd = c; addr = a; wr_data = wd; data_mask = m;
    if (r) begin
`ifdef BURST_RAM_INIT_DELAY_EN
      busy_until = cyc + 17;
`else
      busy_until = 0;
`endif
      rd_start = -1000;
      wr_end   = -1000;
      exp_rd   = '0;
    end else begin
      if (ce && cyc >= busy_until) begin
        if (c) begin
          wr_start = cyc; wr_end = cyc + BC; wr_base = a; busy_until = cyc + BC;
        end else begin
          rd_start = cyc + L; busy_until = cyc + L + BC;
          for (int i = 0; i < BC; i++) rd_snap[i] = mem_m[8'(a + i)];
        end
      end
      if (cyc >= wr_start && cyc < wr_end)
        for (int b = 0; b < 8; b++)
          if (!m[b]) mem_m[8'(wr_base + cyc - wr_start)][8*b +: 8] = wd[8*b +: 8];
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, {$urandom, $urandom}, 8'($urandom));
  endtask

  task automatic wait_free();
    for (int k = 0; k < 64 && cyc < busy_until; k++) idle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d0, input logic [63:0] d1,
                    input logic [63:0] d2, input logic [63:0] d3,
                    input logic [7:0] m0, input logic [7:0] mr);
    step(1'b0, 1'b1, 1'b1, a, d0, m0);
    step(1'b0, 1'b0, 1'b0, 8'h00, d1, mr);
    step(1'b0, 1'b0, 1'b0, 8'h00, d2, mr);
    step(1'b0, 1'b0, 1'b0, 8'h00, d3, mr);
  endtask

  task automatic rd(input logic [7:0] a);
    got.delete();
    step(1'b0, 1'b1, 1'b0, a, 64'h0, 8'h00);
    wait_free();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = '0;
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    chk = 1;
    step(1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    // a command during the optional init window must be dropped
    for (int k = 0; k < 20; k++)
      if (k == 5) step(1'b0, 1'b1, 1'b1, 8'h80, 64'hDEAD, 8'h00);
      else idle();
    for (int a = 0; a < 256; a += 4) wr(8'(a), pat(a), pat(a + 1), pat(a + 2), pat(a + 3), 8'h00, 8'h00);

    wr(8'h10, 64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
       64'h4444444444444444, 8'h00, 8'h00);
    rd(8'h10);
    check("t2_beats", 64'(got.size()), 64'd4);
    check("t2_beat0", gv(0), 64'h1111111111111111);
    check("t2_beat1", gv(1), 64'h2222222222222222);
    check("t2_beat3", gv(3), 64'h4444444444444444);

    wr(8'h10, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0, 64'h0, 8'h0F, 8'hFF);
    rd(8'h10);
    check("t3_beat0", gv(0), 64'hFFFFFFFF11111111);
    check("t3_beat1", gv(1), 64'h2222222222222222);
    check("t3_beat2", gv(2), 64'h3333333333333333);

    got.delete();
    step(1'b0, 1'b1, 1'b0, 8'hFE, 64'h0, 8'h00);
    idle();
    step(1'b0, 1'b1, 1'b1, 8'h20, 64'h0, 8'h00);
    wait_free();
    idle();
    check("t4_beats", 64'(got.size()), 64'd4);
    check("t4_beat0", gv(0), 64'hFEFEFEFEFEFEFEFE);
    check("t4_beat1", gv(1), 64'hFFFFFFFFFFFFFFFF);
    check("t4_beat2", gv(2), 64'h0000000000000000);
    check("t4_beat3", gv(3), 64'h0101010101010101);

    got.delete();
    step(1'b0, 1'b1, 1'b0, 8'h10, 64'h0, 8'h00);
    for (int k = 0; k < 5; k++) idle();
    step(1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 8'h00);
    check("t5_valid_after_rst", 64'(rd_data_valid), 64'd0);
`ifndef BURST_RAM_INIT_DELAY_EN
    check("t5_busy_after_rst", 64'(busy), 64'd0);
`endif
    check("t5_beats_before_rst", 64'(got.size()), 64'd3);
    wait_free();
    rd(8'h10);
    check("t5_reread_beat0", gv(0), 64'hFFFFFFFF11111111);
    check("t5_reread_beat3", gv(3), 64'h4444444444444444);

    for (int n = 0; n < 800; n++)
      step(1'b0 + ($urandom_range(0, 99) == 0), $urandom_range(0, 2) == 0, 1'($urandom),
           $urandom_range(0, 3) == 0 ? 8'(252 + $urandom_range(0, 3)) : 8'($urandom),
           {$urandom, $urandom}, $urandom_range(0, 1) == 0 ? 8'h00 : 8'($urandom));
    wait_free();
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
